// File: rtl/gate_seq_pkg.sv
// Shared state encoding and default sizing for the gate vector sequencer.
package gate_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEF_N_IN   = 2;
  localparam int DEF_SETTLE = 4;
  localparam int DEF_CNT_W  = 8;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that paces how long each vector is held before compare.
module settle_timer #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/gate_vector_sequencer.sv
// Steps every input vector onto two implementations of one identity, holds it SETTLE
// cycles, compares the outputs and reports mismatch count, first failing vector and pass.
module gate_vector_sequencer
  import gate_seq_pkg::*;
#(
  parameter int N_IN   = DEF_N_IN,
  parameter int SETTLE = DEF_SETTLE,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [N_IN-1:0]  vec_out,
  input  logic             lhs_in,
  input  logic             rhs_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic             fail_valid,
  output logic [N_IN-1:0]  fail_vec,
  output logic [1:0]       dbg_state
);

  // Handshake: start is a level sampled only in IDLE; the sampling edge accepts the run and
  // raises busy. busy drops when DONE exits, on the same edge that raises the one-cycle done
  // pulse together with the updated pass. abort ends a run silently (no done pulse).

  localparam int TW = $clog2(SETTLE + 1);
  localparam logic [TW-1:0] TLOAD = TW'(SETTLE - 1);

  state_t state, next_state;
  logic   tmr_load, tmr_dec, tmr_zero;
  logic   chk_upd, mismatch, last_vec;

  assign dbg_state = state;
  assign mismatch  = lhs_in ^ rhs_in;
  assign last_vec  = &vec_out;
  assign chk_upd   = (state == ST_CHECK) && !abort;

  settle_timer #(.WIDTH(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (TLOAD),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    tmr_load   = 1'b0;
    tmr_dec    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          next_state = ST_APPLY;
          tmr_load   = 1'b1;
        end
      end
      ST_APPLY: begin
        if (abort)         next_state = ST_IDLE;
        else if (tmr_zero) next_state = ST_CHECK;
        else               tmr_dec    = 1'b1;
      end
      ST_CHECK: begin
        if (abort) begin
          next_state = ST_IDLE;
        end else if (last_vec) begin
          next_state = ST_DONE;
        end else begin
          next_state = ST_APPLY;
          tmr_load   = 1'b1;
        end
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_out    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else begin
      done <= (state == ST_DONE);

      if ((state == ST_IDLE) && start) begin
        vec_out    <= '0;
        err_cnt    <= '0;
        fail_valid <= 1'b0;
        pass       <= 1'b0;
        busy       <= 1'b1;
      end

      if (((state == ST_APPLY) || (state == ST_CHECK)) && abort) busy <= 1'b0;

      if (chk_upd) begin
        if (mismatch) begin
          if (!(&err_cnt)) err_cnt <= err_cnt + CNT_W'(1);
          if (!fail_valid) begin
            fail_vec   <= vec_out;
            fail_valid <= 1'b1;
          end
        end
        if (!last_vec) vec_out <= vec_out + N_IN'(1);
      end

      // err_cnt already includes the final CHECK by the time DONE is reached.
      if (state == ST_DONE) begin
        pass <= (err_cnt == '0);
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Directed bench for gate_vector_sequencer: table of full runs plus hand-written
// abort, held-start, reset and saturation sequences.
module tb_gate_vector_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       lhs, rhs, flip;
  logic [1:0] vec_out, fail_vec, dbg_state;
  logic       busy, done, pass, fail_valid;
  logic [7:0] err_cnt;
  logic [1:0] mode = 2'd0;

  logic       start3 = 1'b0;
  logic       abort3 = 1'b0;
  logic       lhs3, rhs3;
  logic [2:0] vec3, fvec3;
  logic [1:0] err3, st3;
  logic       busy3, done3, pass3, fv3;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] exp_err;
    logic       exp_fv;
    logic [1:0] exp_fvec;
    logic       exp_pass;
  } vec_t;
  vec_t tbl[4];

  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  // mode 0 correct, 1 flip at 2'b10, 2 flip at 1 and 3, 3 always flipped
  always_comb begin
    flip = 1'b0;
    case (mode)
      2'd1: flip = (vec_out == 2'd2);
      2'd2: flip = (vec_out == 2'd1) || (vec_out == 2'd3);
      2'd3: flip = 1'b1;
      default: flip = 1'b0;
    endcase
    lhs  = ~(vec_out[0] & vec_out[1]);
    rhs  = (~vec_out[0] | ~vec_out[1]) ^ flip;
    lhs3 = ~(&vec3);
    rhs3 = ~lhs3;
  end

  gate_vector_sequencer #(.N_IN(2), .SETTLE(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .vec_out(vec_out),
    .lhs_in(lhs), .rhs_in(rhs), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .fail_valid(fail_valid), .fail_vec(fail_vec), .dbg_state(dbg_state)
  );

  gate_vector_sequencer #(.N_IN(3), .SETTLE(4), .CNT_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .vec_out(vec3),
    .lhs_in(lhs3), .rhs_in(rhs3), .busy(busy3), .done(done3), .pass(pass3),
    .err_cnt(err3), .fail_valid(fv3), .fail_vec(fvec3), .dbg_state(st3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_full(input int idx);
    int   k;
    logic seq_ok;
    logic [1:0] e;
    mode = tbl[idx].mode;
    exp_q.delete();
    for (int j = 0; j <= 20; j++) exp_q.push_back((j < 20) ? 2'(j / 5) : 2'd3);
    start = 1'b1;
    tick();
    start  = 1'b0;
    k      = 0;
    seq_ok = 1'b1;
    while ((k < 60) && !done) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if ((vec_out !== e) || (busy !== 1'b1)) seq_ok = 1'b0;
      end
      tick();
      k++;
    end
    check($sformatf("run%0d_latency", idx), k, 21);
    check($sformatf("run%0d_vec_seq", idx), {31'd0, seq_ok}, 1);
    check($sformatf("run%0d_err_cnt", idx), {24'd0, err_cnt}, {24'd0, tbl[idx].exp_err});
    check($sformatf("run%0d_fail_valid", idx), {31'd0, fail_valid}, {31'd0, tbl[idx].exp_fv});
    if (tbl[idx].exp_fv)
      check($sformatf("run%0d_fail_vec", idx), {30'd0, fail_vec}, {30'd0, tbl[idx].exp_fvec});
    check($sformatf("run%0d_pass", idx), {31'd0, pass}, {31'd0, tbl[idx].exp_pass});
    check($sformatf("run%0d_busy_end", idx), {31'd0, busy}, 0);
    tick();
    check($sformatf("run%0d_done_pulse", idx), {31'd0, done}, 0);
    check($sformatf("run%0d_pass_hold", idx), {31'd0, pass}, {31'd0, tbl[idx].exp_pass});
  endtask

  initial begin
    int   k;
    logic saw_done;

    tbl[0] = '{2'd0, 8'd0, 1'b0, 2'd0, 1'b1};
    tbl[1] = '{2'd1, 8'd1, 1'b1, 2'd2, 1'b0};
    tbl[2] = '{2'd2, 8'd2, 1'b1, 2'd1, 1'b0};
    tbl[3] = '{2'd3, 8'd4, 1'b1, 2'd0, 1'b0};

    tick();
    tick();
    check("rst_vec", {30'd0, vec_out}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_pass", {31'd0, pass}, 0);
    check("rst_err", {24'd0, err_cnt}, 0);
    check("rst_fv", {31'd0, fail_valid}, 0);
    check("rst_state", {30'd0, dbg_state}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) run_full(i);

    // saturation on the 3-input, 2-bit counter instance
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    k = 0;
    while ((k < 100) && !done3) begin
      tick();
      k++;
    end
    check("sat_latency", k, 41);
    check("sat_err", {30'd0, err3}, 3);
    check("sat_fv", {31'd0, fv3}, 1);
    check("sat_fvec", {29'd0, fvec3}, 0);
    check("sat_pass", {31'd0, pass3}, 0);

    // abort in APPLY at +7, then restart 3 cycles later
    mode = 2'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_state", {30'd0, dbg_state}, 0);
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_vec", {30'd0, vec_out}, 1);
    check("abort_err_hold", {24'd0, err_cnt}, 1);
    check("abort_fv_hold", {31'd0, fail_valid}, 1);
    check("abort_fvec_hold", {30'd0, fail_vec}, 0);
    check("abort_pass", {31'd0, pass}, 0);
    saw_done = 1'b0;
    repeat (3) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", {31'd0, saw_done}, 0);
    run_full(0);

    // abort during CHECK wins over the compare update
    mode = 2'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("abchk_in_check", {30'd0, dbg_state}, 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abchk_state", {30'd0, dbg_state}, 0);
    check("abchk_err", {24'd0, err_cnt}, 0);
    check("abchk_fv", {31'd0, fail_valid}, 0);
    check("abchk_vec", {30'd0, vec_out}, 0);

    // start held high: next run only after DONE -> IDLE
    mode = 2'd0;
    start = 1'b1;
    tick();
    k = 0;
    while ((k < 60) && !done) begin
      tick();
      k++;
    end
    check("held_latency", k, 21);
    check("held_pass", {31'd0, pass}, 1);
    tick();
    check("held_restart_state", {30'd0, dbg_state}, 1);
    check("held_restart_busy", {31'd0, busy}, 1);
    check("held_restart_vec", {30'd0, vec_out}, 0);
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("held_abort_idle", {30'd0, dbg_state}, 0);

    // asynchronous reset mid-run
    mode = 2'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    check("prerst_err", {24'd0, err_cnt}, 1);
    check("prerst_fvec", {30'd0, fail_vec}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_vec", {30'd0, vec_out}, 0);
    check("arst_busy", {31'd0, busy}, 0);
    check("arst_done", {31'd0, done}, 0);
    check("arst_err", {24'd0, err_cnt}, 0);
    check("arst_fv", {31'd0, fail_valid}, 0);
    check("arst_fvec", {30'd0, fail_vec}, 0);
    check("arst_state", {30'd0, dbg_state}, 0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_full(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
